registered_comparator: RTL and testbench
========================================

Name:
registered_comparator

Overview:
- Magnitude comparator with registered outputs.
- Compares operands a and b once per clock and drives three mutually exclusive flags: gt, ls, eq.
- Default configuration is a 1-bit unsigned compare. Width and signedness are parameterised for reuse in datapath status logic.
- Sits directly after operand registers. Results are synchronous to clk.

Parameters:
- WIDTH, 1: operand width in bits; legal range is 1 to 64.
- SIGNED, 0: 0 compares a and b as unsigned; 1 compares them as two's-complement signed.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous active-low reset; sampled on rising clk edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- gt  output  1  registered flag, a > b.
- ls  output  1  registered flag, a < b.
- eq  output  1  registered flag, a == b.

Behaviour:
- All outputs are flops updated on the rising edge of clk only. No combinational path from a or b to the outputs.
- Reset:
  - rst is synchronous and active-low.
  - On a rising edge with rst==0: gt=0, ls=0, eq=0. This all-zero state means "no result".
  - Outputs hold 0 while rst stays low, regardless of a and b.
  - Asserting rst while operating clears all flags at the next edge. No asynchronous effect.
- Normal operation, on a rising edge with rst==1:
  - Sample a and b.
  - gt <= (a > b), ls <= (a < b), eq <= (a == b).
- Latency:
  - Exactly 1 cycle. A result reflects the operands present at the edge where it updates.
  - Operand changes between edges have no effect until the next edge.
  - Reset release: first valid flags appear at the first rising edge with rst==1.
- Invariant: out of reset, exactly one of gt, ls, eq is 1 (one-hot). In reset, all three are 0.
- Arithmetic, SIGNED=0: unsigned magnitude compare over the full WIDTH bits.
- Arithmetic, SIGNED=1:
  - The MSB is the sign bit.
  - Negative is less than non-negative.
  - Same-sign operands compare by their remaining bits.
  - WIDTH=1 with SIGNED=1: value 1 represents -1, so a=1, b=0 gives ls=1.
- Boundaries:
  - a=b=0 -> eq.
  - a=b=all-ones -> eq.
  - Unsigned: all-ones vs 0 -> gt.
  - Signed: most-negative vs most-positive -> ls.
- X or Z on operands is outside the contract. No X-propagation handling is required.
- Implementation: either a single comparison operator, or an explicit MSB-first priority scan over the bits (gt/ls decided at the first differing bit). Both are acceptable. Signed mode inverts the decision at the MSB.

Test Plan:
- rst=0 for 2 edges with a=1, b=0 -> gt=ls=eq=0 after each edge. Release rst=1, a=0, b=0 -> eq=1, gt=0, ls=0 after the next edge.
- WIDTH=1, rst=1, sequence a/b = 0/0, 1/0, 1/1, 0/1, each held one clock (10-time-unit period) -> flags one edge later are eq, gt, eq, ls. Exactly one flag high at every edge.
- Operand changes mid-cycle: change a=1 at edge+2 and back to a=0 at edge+4 within one period, b=0 -> flags unchanged until the next edge. Only the value present at the edge is reflected.
- Reset mid-operation: gt=1 (a=1, b=0), drive rst=0 at an edge -> gt=ls=eq=0 at that edge. Restore rst=1 -> gt=1 on the following edge.
- WIDTH=8, SIGNED=0: a=8'hFF, b=8'h00 -> gt=1. a=8'h7F, b=8'h80 -> ls=1. a=b=8'hA5 -> eq=1.
- WIDTH=4, SIGNED=1: a=4'hF (-1), b=4'h1 -> ls=1. a=4'h8 (-8), b=4'h7 -> ls=1. a=4'h7, b=4'hE (-2) -> gt=1. a=b=4'h8 -> eq=1.

Source files
------------

// File: rtl/registered_comparator.sv
// Registered magnitude comparator: one-hot gt/ls/eq flags, one cycle after the operands.
// All-zero flags mean "no result" and are held while rst (sync, active-low) is low.
module registered_comparator #(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             ls,
  output logic             eq
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned compare serves both modes.
  localparam logic [WIDTH-1:0] SMASK = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0] a_cmp, b_cmp;
  logic             gt_d, ls_d, eq_d;
  logic             gt_q, ls_q, eq_q;

  always_comb begin
    a_cmp = a ^ SMASK;
    b_cmp = b ^ SMASK;
    gt_d  = a_cmp > b_cmp;
    ls_d  = a_cmp < b_cmp;
    eq_d  = a_cmp == b_cmp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gt_q <= 1'b0;
      ls_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      ls_q <= ls_d;
      eq_q <= eq_d;
    end
  end

  assign gt = gt_q;
  assign ls = ls_q;
  assign eq = eq_q;

endmodule

// File: tb/tb_registered_comparator.sv
// Bench for registered_comparator: four configurations checked against an integer-value model.
module tb_registered_comparator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a1, b1, a1s, b1s;
  logic [7:0] a8, b8;
  logic [3:0] a4s, b4s;
  logic gt1, ls1, eq1, gt1s, ls1s, eq1s, gt8, ls8, eq8, gt4s, ls4s, eq4s;

  int checks = 0;
  int errors = 0;

  registered_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .gt(gt1), .ls(ls1), .eq(eq1));
  registered_comparator #(.WIDTH(1), .SIGNED(1'b1)) u_w1s (
    .clk(clk), .rst(rst), .a(a1s), .b(b1s), .gt(gt1s), .ls(ls1s), .eq(eq1s));
  registered_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .gt(gt8), .ls(ls8), .eq(eq8));
  registered_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
    .clk(clk), .rst(rst), .a(a4s), .b(b4s), .gt(gt4s), .ls(ls4s), .eq(eq4s));

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got {gt,ls,eq}=%b want %b", tag, obs, exp);
    end
  endtask

  // Numeric value of a w-bit pattern, two's complement when s is set.
  function automatic longint val(input logic [63:0] x, input int w, input bit s);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [2:0] model(input logic r, input longint av, input longint bv);
    if (!r)      return 3'b000;
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b010;
    return 3'b001;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Predict from the values present at the coming edge, clock, then compare.
  task automatic step(input string tag);
    logic [2:0] e1, e1s, e8, e4s;
    e1  = model(rst, val(64'(a1), 1, 0),  val(64'(b1), 1, 0));
    e1s = model(rst, val(64'(a1s), 1, 1), val(64'(b1s), 1, 1));
    e8  = model(rst, val(64'(a8), 8, 0),  val(64'(b8), 8, 0));
    e4s = model(rst, val(64'(a4s), 4, 1), val(64'(b4s), 4, 1));
    tick();
    chk({tag, ":w1"},  {gt1, ls1, eq1},    e1);
    chk({tag, ":w1s"}, {gt1s, ls1s, eq1s}, e1s);
    chk({tag, ":w8"},  {gt8, ls8, eq8},    e8);
    chk({tag, ":w4s"}, {gt4s, ls4s, eq4s}, e4s);
  endtask

  task automatic set_all(input logic [7:0] av, input logic [7:0] bv);
    a1 = av[0]; b1 = bv[0]; a1s = av[0]; b1s = bv[0];
    a8 = av;    b8 = bv;    a4s = av[3:0]; b4s = bv[3:0];
  endtask

  initial begin
    set_all(8'h01, 8'h00);
    rst = 1'b0;
    step("rst_hold0");
    step("rst_hold1");
    rst = 1'b1;
    set_all(8'h00, 8'h00);
    step("rst_release_eq");

    // 1-bit sequence 0/0, 1/0, 1/1, 0/1
    set_all(8'h01, 8'h00); step("seq_10");
    set_all(8'h01, 8'h01); step("seq_11");
    set_all(8'h00, 8'h01); step("seq_01");
    set_all(8'h00, 8'h00); step("seq_00");

    // Operand glitch between edges must not reach the flags
    #1; a1 = 1'b1;
    chk("midcycle_a1", {gt1, ls1, eq1}, 3'b001);
    #2; a1 = 1'b0;
    chk("midcycle_a0", {gt1, ls1, eq1}, 3'b001);
    step("midcycle_edge");

    // Reset asserted mid-operation, then released
    set_all(8'h01, 8'h00); step("pre_rst_gt");
    rst = 1'b0; step("mid_rst");
    rst = 1'b1; step("post_rst_gt");

    // Boundary and directed cases
    set_all(8'hFF, 8'h00); step("ones_vs_zero");
    set_all(8'hFF, 8'hFF); step("ones_eq");
    set_all(8'h7F, 8'h80); step("7f_vs_80");
    set_all(8'hA5, 8'hA5); step("a5_eq");
    set_all(8'h0F, 8'h01); step("neg1_vs_1");
    set_all(8'h08, 8'h07); step("minneg_vs_maxpos");
    set_all(8'h07, 8'h0E); step("7_vs_neg2");
    set_all(8'h08, 8'h08); step("8_eq");

    // Explicit spot checks of the required directed results
    a4s = 4'h8; b4s = 4'h7; tick();
    chk("w4s_minneg_ls", {gt4s, ls4s, eq4s}, 3'b010);
    a1s = 1'b1; b1s = 1'b0; tick();
    chk("w1s_neg1_ls", {gt1s, ls1s, eq1s}, 3'b010);

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(15) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom);
      a1s = 1'($urandom); b1s = 1'($urandom);
      a8 = 8'($urandom); b8 = ($urandom_range(3) == 0) ? a8 : 8'($urandom);
      a4s = 4'($urandom); b4s = ($urandom_range(3) == 0) ? a4s : 4'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
